// File: rtl/lmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// lmem_port_arbiter
//   Shares one layer-memory port between two engines:
//     requester 0 : conv / L0 writer
//     requester 1 : maxpool / L1 reader-writer
//   One memory op is issued per cycle. All memory-side outputs are registered.
//   Read data is returned to the requester that issued the read, two cycles
//   after its grant.
//
// Parameters
//   AW        address width ({y[5:0],x[5:0]} for a 64x64 image)
//   DW        data width (Q4.16)
//   SW        memory-select width
//   FIXED_PRI 0: round-robin between requesters, 1: requester 0 always wins
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   pause                      blocks new grants; an in-flight read still returns
//   rN_req/we/addr/wdata/sel   request from engine N, held stable until rN_gnt
//   rN_gnt                     combinational accept, request consumed this edge
//   rN_rvalid/rN_rdata         one-cycle read-return pulse; rdata holds after it
//   cwr/caddr_wr/cdata_wr      memory write strobe, address, data
//   crd/caddr_rd/cdata_rd      memory read strobe, address, data (same cycle)
//   csel                       memory select of the op currently on the port
//   busy                       a read is in flight or any requester is asking
// -----------------------------------------------------------------------------
module lmem_port_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 20,
  parameter int SW        = 3,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pause,

  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic [SW-1:0] r0_sel,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,

  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  input  logic [SW-1:0] r1_sel,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,

  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic [SW-1:0] csel,
  output logic          busy
);

  // Priority pointer: 0 -> requester 0 wins a tie, 1 -> requester 1 wins.
  logic          ptr_q, ptr_d;

  // Memory-side issue registers.
  logic          cwr_q, cwr_d;
  logic          crd_q, crd_d;
  logic [AW-1:0] caddr_wr_q, caddr_wr_d;
  logic [DW-1:0] cdata_wr_q, cdata_wr_d;
  logic [AW-1:0] caddr_rd_q, caddr_rd_d;
  logic [SW-1:0] csel_q, csel_d;

  // Owner of the read currently on the port (meaningful only while crd_q).
  logic          rd_owner_q, rd_owner_d;

  // Read-return registers.
  logic          r0_rvalid_q, r0_rvalid_d;
  logic          r1_rvalid_q, r1_rvalid_d;
  logic [DW-1:0] r0_rdata_q, r0_rdata_d;
  logic [DW-1:0] r1_rdata_q, r1_rdata_d;

  // Fields of the winning request.
  logic          gnt_any;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic [SW-1:0] win_sel;

  // Grants are also held low during reset so every output reads 0 then.
  always_comb begin : arbitrate
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (!reset && !pause) begin
      if (r0_req && r1_req) begin
        if (FIXED_PRI != 0 || !ptr_q) r0_gnt = 1'b1;
        else                          r1_gnt = 1'b1;
      end else begin
        r0_gnt = r0_req;
        r1_gnt = r1_req;
      end
    end
  end

  always_comb begin : next_state
    gnt_any   = r0_gnt | r1_gnt;
    win_we    = r1_gnt ? r1_we    : r0_we;
    win_addr  = r1_gnt ? r1_addr  : r0_addr;
    win_wdata = r1_gnt ? r1_wdata : r0_wdata;
    win_sel   = r1_gnt ? r1_sel   : r0_sel;

    // Loser of this grant gets priority next time; no grant, no change.
    ptr_d = ptr_q;
    if (r0_gnt)      ptr_d = 1'b1;
    else if (r1_gnt) ptr_d = 1'b0;

    cwr_d      = gnt_any &  win_we;
    crd_d      = gnt_any & ~win_we;
    // Addresses and select hold when idle; write data is zeroed unless writing.
    caddr_wr_d = cwr_d   ? win_addr  : caddr_wr_q;
    cdata_wr_d = cwr_d   ? win_wdata : '0;
    caddr_rd_d = crd_d   ? win_addr  : caddr_rd_q;
    csel_d     = gnt_any ? win_sel   : csel_q;
    rd_owner_d = crd_d   ? r1_gnt    : rd_owner_q;

    // The memory answers in the cycle crd is high; capture it for the owner.
    r0_rvalid_d = crd_q & ~rd_owner_q;
    r1_rvalid_d = crd_q &  rd_owner_q;
    r0_rdata_d  = r0_rvalid_d ? cdata_rd : r0_rdata_q;
    r1_rdata_d  = r1_rvalid_d ? cdata_rd : r1_rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // Reset empties the read pipeline, so an in-flight read is dropped.
      ptr_q       <= 1'b0;
      cwr_q       <= 1'b0;
      crd_q       <= 1'b0;
      caddr_wr_q  <= '0;
      cdata_wr_q  <= '0;
      caddr_rd_q  <= '0;
      csel_q      <= '0;
      rd_owner_q  <= 1'b0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      ptr_q       <= ptr_d;
      cwr_q       <= cwr_d;
      crd_q       <= crd_d;
      caddr_wr_q  <= caddr_wr_d;
      cdata_wr_q  <= cdata_wr_d;
      caddr_rd_q  <= caddr_rd_d;
      csel_q      <= csel_d;
      rd_owner_q  <= rd_owner_d;
      r0_rvalid_q <= r0_rvalid_d;
      r1_rvalid_q <= r1_rvalid_d;
      r0_rdata_q  <= r0_rdata_d;
      r1_rdata_q  <= r1_rdata_d;
    end
  end

  assign cwr       = cwr_q;
  assign crd       = crd_q;
  assign caddr_wr  = caddr_wr_q;
  assign cdata_wr  = cdata_wr_q;
  assign caddr_rd  = caddr_rd_q;
  assign csel      = csel_q;
  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;

  // A read is in flight from issue on the port until its data is captured.
  assign busy = ~reset & (crd_q | r0_req | r1_req);

endmodule

// File: tb/tb_lmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lmem_port_arbiter
//   Drives two requesters, models the layer memory, and checks the arbiter
//   against a transaction-level reference: who should win each cycle, which
//   memory op should appear one cycle later, and which data each requester
//   should receive two cycles after a read grant. Expected memory ops and read
//   returns are queued at grant time and consumed by an independent monitor.
// -----------------------------------------------------------------------------
module tb_lmem_port_arbiter;

  localparam int AW        = 12;
  localparam int DW        = 20;
  localparam int SW        = 3;
  localparam int FIXED_PRI = 0;

  logic          clk, reset, pause;
  logic          r0_req, r0_we, r0_gnt, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic [SW-1:0] r0_sel;
  logic          r1_req, r1_we, r1_gnt, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic [SW-1:0] r1_sel;
  logic          cwr, crd, busy;
  logic [AW-1:0] caddr_wr, caddr_rd;
  logic [DW-1:0] cdata_wr, cdata_rd;
  logic [SW-1:0] csel;

  lmem_port_arbiter #(.AW(AW), .DW(DW), .SW(SW), .FIXED_PRI(FIXED_PRI)) dut (
    .clk(clk), .reset(reset), .pause(pause),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_sel(r0_sel), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_sel(r1_sel), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .csel(csel), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // ---------------- memory model ------------------------------------------
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a, a[7:0]} ^ 20'h5A5A5;
  endfunction

  logic [DW-1:0] mem [4096];
  bit            written [4096];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  always @(posedge clk) begin
    if (cwr) begin
      mem[caddr_wr]     <= cdata_wr;
      written[caddr_wr] <= 1'b1;
    end else if (ld_en) begin
      mem[ld_addr]      <= ld_data;
      written[ld_addr]  <= 1'b1;
    end
  end

  assign cdata_rd = crd ? (written[caddr_rd] ? mem[caddr_rd] : init_val(caddr_rd)) : '0;

  // ---------------- scoreboard state --------------------------------------
  typedef struct {
    int            cyc;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
  } mem_op_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } ret_t;

  mem_op_t       mem_q[$];
  ret_t          ret_q0[$];
  ret_t          ret_q1[$];
  logic [DW-1:0] ref_mem [4096];
  int            ptr_m;
  logic [DW-1:0] last_rd [2];
  int            gcnt [2];

  // Requester-side state: a pending request is held until granted.
  bit            pend [2];
  bit            p_we [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];
  logic [SW-1:0] p_sel [2];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic post(input int n, input bit we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [SW-1:0] sel);
    if (!pend[n]) begin
      pend[n] = 1'b1; p_we[n] = we; p_addr[n] = addr; p_wdata[n] = wdata; p_sel[n] = sel;
    end
  endtask

  task automatic post_rand(input int n);
    logic [AW-1:0] a;
    if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(0, 4095));
    else                           a = AW'($urandom_range(0, 15));
    post(n, bit'($urandom_range(0, 1)), a, DW'($urandom_range(0, 20'hFFFFF)),
         SW'($urandom_range(0, 7)));
  endtask

  // One clock cycle: drive inputs after the edge, then predict the grant and
  // queue the resulting memory op and read return.
  task automatic step(input bit pause_v, input bit rst_v);
    bit      e0, e1;
    int      n;
    mem_op_t op;
    ret_t    rt;
    @(posedge clk);
    #1;
    reset = rst_v;  pause = pause_v;
    r0_req = pend[0]; r0_we = p_we[0]; r0_addr = p_addr[0]; r0_wdata = p_wdata[0]; r0_sel = p_sel[0];
    r1_req = pend[1]; r1_we = p_we[1]; r1_addr = p_addr[1]; r1_wdata = p_wdata[1]; r1_sel = p_sel[1];
    #3;
    e0 = 1'b0; e1 = 1'b0;
    if (!rst_v && !pause_v) begin
      if (pend[0] && pend[1]) begin
        if (FIXED_PRI != 0 || ptr_m == 0) e0 = 1'b1;
        else                              e1 = 1'b1;
      end else begin
        e0 = pend[0]; e1 = pend[1];
      end
    end
    check("gnt", {r0_gnt, r1_gnt}, {e0, e1});
    if (r0_gnt) gcnt[0]++;
    if (r1_gnt) gcnt[1]++;
    if (rst_v) begin
      ptr_m = 0;
      mem_q.delete(); ret_q0.delete(); ret_q1.delete();
    end else if (e0 || e1) begin
      n = e1 ? 1 : 0;
      if (FIXED_PRI == 0) ptr_m = 1 - n;
      op.cyc = cyc + 1; op.we = p_we[n]; op.addr = p_addr[n];
      op.data = p_wdata[n]; op.sel = p_sel[n];
      mem_q.push_back(op);
      if (p_we[n]) ref_mem[p_addr[n]] = p_wdata[n];
      else begin
        rt.cyc = cyc + 2; rt.data = ref_mem[p_addr[n]];
        if (n == 0) ret_q0.push_back(rt); else ret_q1.push_back(rt);
      end
      pend[n] = 1'b0;
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    ref_mem[a] = d;
    step(1'b0, 1'b0);
    ld_en = 1'b0;
  endtask

  task automatic drain();
    int  k = 0;
    bit  idle;
    idle = 1'b0;
    while (k < 40 && !idle) begin
      step(1'b0, 1'b0);
      k++;
      idle = !pend[0] && !pend[1] && mem_q.size() == 0 && ret_q0.size() == 0 && ret_q1.size() == 0;
    end
    check("drain", idle, 1'b1);
  endtask

  // ---------------- monitor -----------------------------------------------
  task automatic mon_ret(input int n, input logic rv, input logic [DW-1:0] rd);
    ret_t e;
    bit   have;
    have = (n == 0) ? (ret_q0.size() > 0) : (ret_q1.size() > 0);
    if (have) begin
      if (n == 0) e = ret_q0[0]; else e = ret_q1[0];
    end
    if (rv) begin
      if (!have) check($sformatf("r%0d_rvalid_unexpected", n), rv, 1'b0);
      else begin
        if (n == 0) e = ret_q0.pop_front(); else e = ret_q1.pop_front();
        check($sformatf("r%0d_ret_cycle", n), cyc, e.cyc);
        check($sformatf("r%0d_rdata", n), rd, e.data);
        last_rd[n] = e.data;
      end
    end else begin
      if (have && e.cyc <= cyc) begin
        if (n == 0) e = ret_q0.pop_front(); else e = ret_q1.pop_front();
        check($sformatf("r%0d_rvalid_missing", n), rv, 1'b1);
      end
      check($sformatf("r%0d_rdata_hold", n), rd, last_rd[n]);
    end
  endtask

  initial begin : monitor
    mem_op_t       op;
    bit            have_op;
    logic [AW-1:0] l_awr, l_ard;
    logic [SW-1:0] l_sel;
    l_awr = '0; l_ard = '0; l_sel = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        l_awr = '0; l_ard = '0; l_sel = '0;
        last_rd[0] = '0; last_rd[1] = '0;
        check("reset_ctrl", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, cwr, crd, busy, csel}, '0);
        check("reset_rdata", {r0_rdata, r1_rdata}, '0);
        check("reset_addr", {caddr_wr, caddr_rd, cdata_wr}, '0);
      end else begin
        have_op = 1'b0;
        while (mem_q.size() > 0 && mem_q[0].cyc < cyc) begin
          op = mem_q.pop_front();
          check("mem_op_stale", cyc, op.cyc);
        end
        if (mem_q.size() > 0 && mem_q[0].cyc == cyc) begin
          op = mem_q.pop_front();
          have_op = 1'b1;
        end
        if (have_op && op.we) begin
          check("mem_write", {cwr, crd, caddr_wr, cdata_wr, csel}, {2'b10, op.addr, op.data, op.sel});
          check("mem_write_rdaddr_hold", caddr_rd, l_ard);
          l_awr = op.addr; l_sel = op.sel;
        end else if (have_op) begin
          check("mem_read", {cwr, crd, caddr_rd, csel}, {2'b01, op.addr, op.sel});
          check("mem_read_wraddr_hold", caddr_wr, l_awr);
          l_ard = op.addr; l_sel = op.sel;
        end else begin
          check("mem_idle", {cwr, crd, caddr_wr, cdata_wr, caddr_rd, csel},
                {2'b00, l_awr, 20'h0, l_ard, l_sel});
        end
        check("busy", busy, r0_req | r1_req | (have_op && !op.we));
        mon_ret(0, r0_rvalid, r0_rdata);
        mon_ret(1, r1_rvalid, r1_rdata);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d failed so far", fails);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------------------------------------
  initial begin : stimulus
    int d;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(AW'(i));
    for (int n = 0; n < 2; n++) begin
      pend[n] = 1'b0; p_we[n] = 1'b0; p_addr[n] = '0; p_wdata[n] = '0; p_sel[n] = '0;
      gcnt[n] = 0;
    end
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    pause = 1'b0; reset = 1'b0;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0; r0_sel = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0; r1_sel = '0;
    ptr_m = 0;
    #2 reset = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Single write from requester 0.
    post(0, 1'b1, 12'h041, 20'h01310, 3'd1);
    step(1'b0, 1'b0);
    drain();

    // Both requesting every cycle: strict alternation, balanced counts.
    gcnt[0] = 0; gcnt[1] = 0;
    for (int i = 0; i < 100; i++) begin
      post_rand(0);
      post_rand(1);
      step(1'b0, 1'b0);
    end
    d = gcnt[0] - gcnt[1];
    check("fair_balance", (d <= 1 && d >= -1), 1'b1);
    check("fair_total", gcnt[0] + gcnt[1], 100);
    drain();

    // Back-to-back reads by requester 1.
    load(12'h000, 20'hAAAAA);
    load(12'h001, 20'h55555);
    post(1, 1'b0, 12'h000, '0, 3'd3);
    step(1'b0, 1'b0);
    post(1, 1'b0, 12'h001, '0, 3'd3);
    step(1'b0, 1'b0);
    drain();

    // Write then read of the same address on consecutive grants.
    post(0, 1'b1, 12'h0FF, 20'hFFFFF, 3'd1);
    step(1'b0, 1'b0);
    post(1, 1'b0, 12'h0FF, '0, 3'd3);
    step(1'b0, 1'b0);
    drain();

    // Pause with a read outstanding, then resume to the pointer requester.
    post(0, 1'b0, 12'h005, '0, 3'd1);
    step(1'b0, 1'b0);
    post(0, 1'b1, 12'h006, 20'h12345, 3'd1);
    post(1, 1'b0, 12'h005, '0, 3'd3);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("pause_resume_gnt", {r0_gnt, r1_gnt}, 2'b01);
    drain();

    // Reset the cycle after a read grant: read dropped, pointer back to r0.
    post(0, 1'b0, 12'h123, '0, 3'd1);
    step(1'b0, 1'b0);
    post(0, 1'b1, 12'h200, 20'h00ABC, 3'd1);
    post(1, 1'b1, 12'h201, 20'h00DEF, 3'd3);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("post_reset_gnt", {r0_gnt, r1_gnt}, 2'b10);
    drain();

    // Randomized traffic with occasional pause.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 60) post_rand(0);
      if ($urandom_range(0, 99) < 60) post_rand(1);
      step(bit'($urandom_range(0, 9) == 0), 1'b0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
